// File: rtl/register_divider.sv
// Sequential restoring divider: {DH,DL} / B -> Q, R, one quotient bit per clock.
// Operands are loaded from a shared data bus through per-register enables.
module register_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             EH,
  input  logic             EL,
  input  logic             EB,
  input  logic [WIDTH-1:0] Data,
  input  logic             Start,
  output logic [WIDTH-1:0] DH,
  output logic [WIDTH-1:0] DL,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] dh_r, dh_s;
  logic [WIDTH-1:0] dl_r, dl_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] r_r, r_s;
  logic [WIDTH-1:0] p_r, p_s;
  logic [WIDTH-1:0] s_r, s_s;
  logic [WIDTH-1:0] qs_r, qs_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, done_r, divzero_r, ovf_r;
  logic             divzero_s, ovf_s;

  logic [WIDTH+1:0] trial_s;
  logic             fits_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] qbits_s;
  logic             op_error_s;

  // One restoring step: subtract B from the partial remainder with the next dividend bit appended
  always_comb begin
    trial_s    = {1'b0, p_r, s_r[WIDTH-1]} - {2'b00, b_r};
    fits_s     = ~trial_s[WIDTH+1];
    rem_next_s = fits_s ? trial_s[WIDTH-1:0] : {p_r[WIDTH-2:0], s_r[WIDTH-1]};
    qbits_s    = {qs_r[WIDTH-2:0], fits_s};
    // A quotient wider than WIDTH bits is detected up front from the high half alone
    op_error_s = (b_r == {WIDTH{1'b0}}) || (dh_r >= b_r);
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          state_s = op_error_s ? DONE : RUN;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and status next values
  always_comb begin
    dh_s      = dh_r;
    dl_s      = dl_r;
    b_s       = b_r;
    q_s       = q_r;
    r_s       = r_r;
    p_s       = p_r;
    s_s       = s_r;
    qs_s      = qs_r;
    cnt_s     = cnt_r;
    divzero_s = divzero_r;
    ovf_s     = ovf_r;

    if (state_r != RUN) begin
      dh_s = EH ? Data : dh_r;
      dl_s = EL ? Data : dl_r;
      b_s  = EB ? Data : b_r;
    end else begin
      dh_s = dh_r;
    end

    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          divzero_s = 1'b0;
          ovf_s     = 1'b0;
          if (b_r == {WIDTH{1'b0}}) begin
            divzero_s = 1'b1;
            q_s       = {WIDTH{1'b1}};
            r_s       = {WIDTH{1'b0}};
          end else if (dh_r >= b_r) begin
            ovf_s = 1'b1;
            q_s   = {WIDTH{1'b1}};
            r_s   = {WIDTH{1'b0}};
          end else begin
            p_s   = dh_r;
            s_s   = dl_r;
            qs_s  = {WIDTH{1'b0}};
            cnt_s = CW'(WIDTH);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      RUN: begin
        p_s   = rem_next_s;
        s_s   = {s_r[WIDTH-2:0], 1'b0};
        qs_s  = qbits_s;
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          q_s = qbits_s;
          r_s = rem_next_s;
        end else begin
          q_s = q_r;
        end
      end
      default: begin
        cnt_s = {CW{1'b0}};
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dh_r      <= {WIDTH{1'b0}};
      dl_r      <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      r_r       <= {WIDTH{1'b0}};
      p_r       <= {WIDTH{1'b0}};
      s_r       <= {WIDTH{1'b0}};
      qs_r      <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      dh_r      <= dh_s;
      dl_r      <= dl_s;
      b_r       <= b_s;
      q_r       <= q_s;
      r_r       <= r_s;
      p_r       <= p_s;
      s_r       <= s_s;
      qs_r      <= qs_s;
      cnt_r     <= cnt_s;
      busy_r    <= (state_s == RUN);
      done_r    <= (state_s == DONE);
      divzero_r <= divzero_s;
      ovf_r     <= ovf_s;
    end
  end

  assign DH      = dh_r;
  assign DL      = dl_r;
  assign B       = b_r;
  assign Q       = q_r;
  assign R       = r_r;
  assign Busy    = busy_r;
  assign Done    = done_r;
  assign DivZero = divzero_r;
  assign Ovf     = ovf_r;

endmodule

// File: tb/tb_register_divider.sv
// Directed and randomized self-checking bench for register_divider.
module tb_register_divider;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       EH = 1'b0, EL = 1'b0, EB = 1'b0, Start = 1'b0;
  logic [7:0] Data = 8'h00;
  logic [7:0] DH, DL, B, Q, R;
  logic       Busy, Done, DivZero, Ovf;

  int total = 0;
  int passed = 0;

  register_divider #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .EH(EH), .EL(EL), .EB(EB), .Data(Data), .Start(Start),
    .DH(DH), .DL(DL), .B(B), .Q(Q), .R(R),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] b);
    EH = 1'b1; Data = dh; tick(); EH = 1'b0;
    EL = 1'b1; Data = dl; tick(); EL = 1'b0;
    EB = 1'b1; Data = b;  tick(); EB = 1'b0;
  endtask

  // Pulse Start, then count edges until Done (bounded); returns edge count
  task automatic run_op(output int n);
    Start = 1'b1; tick(); Start = 1'b0;
    n = 0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic full_op(input string tag, input logic [15:0] dvd, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er);
    int n;
    load(dvd[15:8], dvd[7:0], b);
    run_op(n);
    check({tag, "_lat"}, n, 8);
    check({tag, "_q"}, Q, eq);
    check({tag, "_r"}, R, er);
    check({tag, "_flags"}, {Busy, Done, DivZero, Ovf}, 4'b0100);
  endtask

  initial begin
    int n;
    logic [7:0] q0;
    logic [15:0] dvd;
    logic [7:0] rb;

    tick(); tick();
    check("reset_outs", {DH, DL, B, Q, R, Busy, Done, DivZero, Ovf}, 0);
    Rst = 1'b0;
    tick();
    check("idle_outs", {DH, DL, B, Q, R, Busy, Done, DivZero, Ovf}, 0);

    // First operation, also verifying Busy window and Q hold during RUN
    load(8'h0F, 8'hA0, 8'h28);
    check("load_regs", {DH, DL, B}, 24'h0FA028);
    Start = 1'b1; tick(); Start = 1'b0;
    n = 0;
    while (!Done && n < 20) begin
      check("busy_run", Busy, 1'b1);
      if (n == 4) check("q_hold_run", Q, 8'h00);
      tick();
      n++;
    end
    check("op1_lat", n, 8);
    check("op1_qr", {Q, R}, 16'h6400);
    check("op1_flags", {Busy, Done, DivZero, Ovf}, 4'b0100);

    // Loads after completion keep Done/Q/R
    EB = 1'b1; Data = 8'h33; tick(); EB = 1'b0;
    check("load_keeps_done", {Done, Q, R, B}, {1'b1, 24'h640033});

    full_op("op2", 16'h00FF, 8'h10, 8'h0F, 8'h0F);
    full_op("op3", 16'hFE01, 8'hFF, 8'hFF, 8'h00);

    // Divide by zero
    load(8'h12, 8'h34, 8'h00);
    run_op(n);
    check("dz_lat", n, 0);
    check("dz_flags", {Busy, Done, DivZero, Ovf}, 4'b0110);
    check("dz_qr", {Q, R}, 16'hFF00);

    // Overflow then retry
    load(8'h12, 8'h34, 8'h12);
    run_op(n);
    check("ovf_lat", n, 0);
    check("ovf_flags", {Busy, Done, DivZero, Ovf}, 4'b0101);
    check("ovf_qr", {Q, R}, 16'hFF00);
    full_op("retry", 16'h1234, 8'h13, 8'hF5, 8'h05);

    // Disturbance during RUN: load and Start must be ignored
    load(8'h0F, 8'hA0, 8'h28);
    Start = 1'b1; tick(); Start = 1'b0;
    n = 0;
    while (!Done && n < 20) begin
      if (n == 2) begin EB = 1'b1; Data = 8'h01; Start = 1'b1; end
      tick();
      EB = 1'b0; Start = 1'b0;
      n++;
    end
    check("dist_lat", n, 8);
    check("dist_b", B, 8'h28);
    check("dist_qr", {Q, R}, 16'h6400);

    // Reset in the middle of RUN
    load(8'h00, 8'hFF, 8'h10);
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", Busy, 1'b1);
    Rst = 1'b1;
    #1;
    check("mid_rst_outs", {DH, DL, B, Q, R, Busy, Done, DivZero, Ovf}, 0);
    tick();
    Rst = 1'b0;
    tick();
    check("post_rst_idle", {Busy, Done}, 2'b00);
    full_op("post_rst", 16'h0FA0, 8'h28, 8'h64, 8'h00);

    // Random non-error operands against the division identity
    for (int i = 0; i < 200; i++) begin
      rb  = 8'($urandom_range(1, 255));
      dvd = {8'($urandom_range(0, rb - 1)), 8'($urandom_range(0, 255))};
      load(dvd[15:8], dvd[7:0], rb);
      run_op(n);
      check("rnd_lat", n, 8);
      check("rnd_qr", {Q, R}, {8'(dvd / rb), 8'(dvd % rb)});
      check("rnd_inv", {16'(Q * rb + R), 1'(R < rb)}, {dvd, 1'b1});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
